ibex_mem_arb: RTL and testbench
===============================

Name: ibex_mem_arb

Overview:
- Arbitrates the Ibex instruction-fetch port and data port onto one shared memory port that follows the same req/gnt/rvalid protocol.
- Sits between the Ibex core inside the user core wrapper and the SoC memory/bus fabric.
- Tracks outstanding transactions in order and routes each response back to the port that issued it.

Parameters:
- MaxOutstanding, 2, maximum granted-but-unanswered transactions on the shared port (1..8).
- AddrWidth, 32, address width of all ports.
- DataWidth, 32, data width of all ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  AddrWidth  fetch address.
- instr_gnt_o  out  1  fetch grant.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  DataWidth  fetch read data.
- instr_err_o  out  1  fetch bus error.
- data_req_i  in  1  data request.
- data_we_i  in  1  data write enable.
- data_be_i  in  DataWidth/8  data byte enables.
- data_addr_i  in  AddrWidth  data address.
- data_wdata_i  in  DataWidth  data write data.
- data_gnt_o  out  1  data grant.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  DataWidth  data read data.
- data_err_o  out  1  data bus error.
- mem_req_o  out  1  shared request.
- mem_we_o  out  1  shared write enable.
- mem_be_o  out  DataWidth/8  shared byte enables.
- mem_addr_o  out  AddrWidth  shared address.
- mem_wdata_o  out  DataWidth  shared write data.
- mem_gnt_i  in  1  shared grant.
- mem_rvalid_i  in  1  shared response valid.
- mem_rdata_i  in  DataWidth  shared read data.
- mem_err_i  in  1  shared error.
- spurious_rsp_o  out  1  sticky flag: mem_rvalid_i seen with nothing outstanding.

Behaviour:
- Reset, while rst_i=1:
  - All outputs are 0.
  - Outstanding FIFO is emptied and the lock is cleared.
  - last_src is set to DATA, so the first tie goes to INSTR.
  - spurious_rsp_o clears only on reset.
- Request path (combinational, zero added latency):
  - mem_req_o = (instr_req_i | data_req_i) & !full.
  - The selected source drives mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o.
  - For INSTR: mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- Selection:
  - Only one port requests: that port is selected.
  - Both request: round-robin, choosing the source that is not last_src.
  - Lock: if mem_req_o=1 and mem_gnt_i=0, the selection is registered and held until the handshake. This keeps the address stable even if the other port starts requesting.
- Grant:
  - sel_gnt = mem_req_o & mem_gnt_i, routed only to the selected port's gnt output.
  - The unselected port's gnt output is 0.
  - On handshake: last_src <= selected source, lock is released, and the source ID is pushed into the FIFO.
- Outstanding FIFO:
  - Depth MaxOutstanding, 1-bit entries (0=INSTR, 1=DATA).
  - Counter width is $clog2(MaxOutstanding+1).
  - full = (count == MaxOutstanding). While full, mem_req_o=0 and both gnt outputs are 0.
  - An mem_rvalid_i arriving in the same cycle does not unblock the request until the next cycle; there is no rvalid->req combinational path.
- Response:
  - On mem_rvalid_i with the FIFO non-empty, the head is popped and rvalid/rdata/err are routed combinationally to the head's port.
  - The other port's rvalid is 0, and its rdata/err are driven to 0.
- Simultaneous push and pop: count is unchanged and the FIFO pointers advance correctly, including at wrap-around.
- Responses are strictly in grant order. The earliest legal rvalid is the cycle after gnt, so a response in the same cycle as gnt pops the older entry.
- mem_rvalid_i with the FIFO empty: the response is dropped, no port rvalid is driven, and spurious_rsp_o <= 1.
- Reset mid-transaction: in-flight responses are lost. Any rvalid arriving after reset sets spurious_rsp_o.

Optional Feature:
- Macro USER_ARB_PERF_EN.
- Defined:
  - Adds outputs instr_gnt_cnt_o[31:0] and data_gnt_cnt_o[31:0].
  - Each counts handshakes on its port, wraps modulo 2^32, and resets to 0.
  - Also adds stall_cnt_o[31:0], which counts cycles with a request pending but no handshake (including full-blocked cycles).
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- instr_req_i only, addr 0x0000_0080, mem_gnt_i=1, rvalid 1 cycle later with rdata 0xDEADBEEF -> instr_gnt_o=1 in the same cycle; instr_rvalid_o=1 with 0xDEADBEEF; data_rvalid_o=0; mem_be_o=4'hF, mem_we_o=0.
- Both request from reset, mem_gnt_i=1 for 4 cycles -> grants go INSTR, DATA, INSTR, DATA; responses route in the same order.
- data_req_i with addr 0x1000, mem_gnt_i=0 for 3 cycles, instr_req_i asserted in cycle 2 -> mem_addr_o stays 0x1000 until the gnt; DATA wins that handshake.
- MaxOutstanding=2, two handshakes with no rvalid -> mem_req_o=0 while full; an rvalid in cycle N re-enables mem_req_o in cycle N+1.
- mem_rvalid_i with an empty FIFO, mem_err_i=1 -> no port rvalid; spurious_rsp_o=1 and sticky until rst_i.
- rst_i asserted with 1 outstanding, then rvalid -> all outputs 0 during reset; spurious_rsp_o=1 after the rvalid. With USER_ARB_PERF_EN, all counters read 0 after reset.

Source files
------------

// File: rtl/ibex_mem_arb.sv
// rtl/ibex_mem_arb.sv - arbitrates Ibex fetch and data ports onto one req/gnt/rvalid memory port
// Optional grant/stall counters are built when USER_ARB_PERF_EN is defined.
module ibex_mem_arb #(
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   instr_req_i,
  input  logic [AddrWidth-1:0]   instr_addr_i,
  output logic                   instr_gnt_o,
  output logic                   instr_rvalid_o,
  output logic [DataWidth-1:0]   instr_rdata_o,
  output logic                   instr_err_o,
  input  logic                   data_req_i,
  input  logic                   data_we_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic [AddrWidth-1:0]   data_addr_i,
  input  logic [DataWidth-1:0]   data_wdata_i,
  output logic                   data_gnt_o,
  output logic                   data_rvalid_o,
  output logic [DataWidth-1:0]   data_rdata_o,
  output logic                   data_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  input  logic                   mem_err_i,
`ifdef USER_ARB_PERF_EN
  output logic [31:0]            instr_gnt_cnt_o,
  output logic [31:0]            data_gnt_cnt_o,
  output logic [31:0]            stall_cnt_o,
`endif
  output logic                   spurious_rsp_o
);

  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

  typedef enum logic {SRC_INSTR = 1'b0, SRC_DATA = 1'b1} src_e;

  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      lock_q, lock_d;
  src_e                      lock_src_q, lock_src_d, last_src_q, last_src_d;
  logic                      spur_q, spur_d;

  src_e sel, head;
  logic any_req, full, empty, req, hs, pop;

  always_comb begin
    sel = SRC_INSTR;
    if (lock_q) begin
      sel = lock_src_q;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_src_q == SRC_DATA) ? SRC_INSTR : SRC_DATA;
    end else if (data_req_i) begin
      sel = SRC_DATA;
    end
  end

  // full is taken from the registered count so a same-cycle rvalid cannot reopen the request
  assign any_req = instr_req_i | data_req_i;
  assign full    = (count_q == MaxCnt);
  assign empty   = (count_q == '0);
  assign req     = any_req & ~full & ~rst_i;
  assign hs      = req & mem_gnt_i;
  assign pop     = mem_rvalid_i & ~empty & ~rst_i;
  assign head    = src_e'(fifo_q[rptr_q]);

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    data_err_o     = 1'b0;
    if (!rst_i) begin
      mem_req_o = req;
      if (sel == SRC_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        data_gnt_o  = hs;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
        instr_gnt_o = hs;
      end
      if (pop && head == SRC_DATA) begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = mem_rdata_i;
        data_err_o    = mem_err_i;
      end else if (pop) begin
        instr_rvalid_o = 1'b1;
        instr_rdata_o  = mem_rdata_i;
        instr_err_o    = mem_err_i;
      end
    end
  end

  always_comb begin
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    last_src_d = last_src_q;
    spur_d     = spur_q | (mem_rvalid_i & empty);
    if (hs) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
      last_src_d     = sel;
      lock_d         = 1'b0;
    end else if (req) begin
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
    if (pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    end
    if (hs && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !hs) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_INSTR;
      last_src_q <= SRC_DATA;
      spur_q     <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      last_src_q <= last_src_d;
      spur_q     <= spur_d;
    end
  end

  assign spurious_rsp_o = spur_q & ~rst_i;

`ifdef USER_ARB_PERF_EN
  logic [31:0] instr_gnt_cnt_q, data_gnt_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_gnt_cnt_q <= '0;
      data_gnt_cnt_q  <= '0;
      stall_cnt_q     <= '0;
    end else begin
      if (hs && sel == SRC_INSTR) instr_gnt_cnt_q <= instr_gnt_cnt_q + 32'd1;
      if (hs && sel == SRC_DATA)  data_gnt_cnt_q  <= data_gnt_cnt_q + 32'd1;
      if (any_req && !hs)         stall_cnt_q     <= stall_cnt_q + 32'd1;
    end
  end

  assign instr_gnt_cnt_o = rst_i ? 32'd0 : instr_gnt_cnt_q;
  assign data_gnt_cnt_o  = rst_i ? 32'd0 : data_gnt_cnt_q;
  assign stall_cnt_o     = rst_i ? 32'd0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_mem_arb.sv
// tb/tb_ibex_mem_arb.sv - table-driven bench with a response-routing scoreboard for ibex_mem_arb
module tb_ibex_mem_arb;

  localparam logic [31:0] IADDR = 32'h0000_0080;
  localparam logic [31:0] DADDR = 32'h0000_1000;
  localparam logic [31:0] DWDAT = 32'h0000_0055;
  localparam logic [3:0]  DBE   = 4'h3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0, data_req_i = 1'b0, data_we_i = 1'b1;
  logic [31:0] instr_addr_i = IADDR, data_addr_i = DADDR, data_wdata_i = DWDAT;
  logic [3:0]  data_be_i = DBE;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic        mem_req_o, mem_we_o, spurious_rsp_o;
  logic [3:0]  mem_be_o;
`ifdef USER_ARB_PERF_EN
  logic [31:0] instr_gnt_cnt_o, data_gnt_cnt_o, stall_cnt_o;
`endif

  always #5 clk = ~clk;

  ibex_mem_arb dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
`ifdef USER_ARB_PERF_EN
    .instr_gnt_cnt_o(instr_gnt_cnt_o), .data_gnt_cnt_o(data_gnt_cnt_o), .stall_cnt_o(stall_cnt_o),
`endif
    .spurious_rsp_o(spurious_rsp_o)
  );

  typedef struct {
    string       name;
    logic        rst, ireq, dreq, gnt, rv;
    logic [31:0] rdata;
    logic        err;
    logic        e_req, e_seld, e_ig, e_dg, e_irv, e_drv, e_spur;
  } vec_t;

  vec_t vecs[$];
  logic sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t row(string n, logic rst, logic ireq, logic dreq, logic gnt, logic rv,
                               logic [31:0] rdata, logic err, logic e_req, logic e_seld,
                               logic e_ig, logic e_dg, logic e_irv, logic e_drv, logic e_spur);
    vec_t v;
    v.name = n; v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.err = err; v.e_req = e_req; v.e_seld = e_seld; v.e_ig = e_ig;
    v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv; v.e_spur = e_spur;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_i = v.rst; instr_req_i = v.ireq; data_req_i = v.dreq;
    mem_gnt_i = v.gnt; mem_rvalid_i = v.rv; mem_rdata_i = v.rdata; mem_err_i = v.err;
  endtask

  task automatic check_row(input vec_t v);
    logic [74:0] got, exp;
    logic [68:0] exp_bus;
    exp_bus = v.e_seld ? {1'b1, DBE, DADDR, DWDAT} : {1'b0, 4'hF, IADDR, 32'h0};
    got = {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, spurious_rsp_o,
           v.e_req ? {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} : 69'h0};
    exp = {v.e_req, v.e_ig, v.e_dg, v.e_irv, v.e_drv, v.e_spur, v.e_req ? exp_bus : 69'h0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", v.name, got, exp);
    end
  endtask

  task automatic check_rsp(input string n);
    logic [65:0] got, exp;
    logic src;
    if (instr_rvalid_o || data_rvalid_o) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s_sb: response with nothing expected", n);
      end else begin
        src = sb.pop_front();
        got = data_rvalid_o ? {1'b1, data_rdata_o, data_err_o, instr_rdata_o}
                            : {1'b0, instr_rdata_o, instr_err_o, data_rdata_o};
        exp = {src, mem_rdata_i, mem_err_i, 32'h0};
        if (got !== exp) begin
          bad++;
          $display("FAIL %s_rsp: got %h want %h", n, got, exp);
        end
      end
    end
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    if (v.rst) sb.delete();
    check_row(v);
    check_rsp(v.name);
    if (v.e_ig) sb.push_back(1'b0);
    if (v.e_dg) sb.push_back(1'b1);
  endtask

  initial begin
    vecs.push_back(row("reset",      1, 1, 1, 1, 1, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row("i_only",     0, 1, 0, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(row("i_rsp",      0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(row("reset2",     1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row("rr0",        0, 1, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(row("rr1",        0, 1, 1, 1, 1, 32'h1111,     0, 1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(row("rr2",        0, 1, 1, 1, 1, 32'h2222,     0, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(row("rr3",        0, 1, 1, 1, 1, 32'h3333,     0, 1, 1, 0, 1, 1, 0, 0));
    vecs.push_back(row("rr_rsp",     0, 0, 0, 0, 1, 32'h4444,     0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(row("lock0",      0, 0, 1, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(row("lock1",      0, 0, 1, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(row("lock2",      0, 1, 1, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(row("lock_gnt",   0, 1, 1, 1, 0, 32'h0,        0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(row("after_lock", 0, 1, 0, 1, 1, 32'h5555,     0, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(row("lock_rsp",   0, 0, 0, 0, 1, 32'h6666,     0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(row("fill0",      0, 1, 0, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(row("fill1",      0, 0, 1, 1, 0, 32'h0,        0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(row("full",       0, 1, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row("full_rv",    0, 1, 1, 1, 1, 32'h7777,     0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(row("unblock",    0, 1, 1, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(row("drain0",     0, 0, 0, 0, 1, 32'h8888,     0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(row("drain1",     0, 0, 0, 0, 1, 32'h9999,     0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(row("spur_rv",    0, 0, 0, 0, 1, 32'hBAD0,     1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row("spur_set",   0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(row("spur_gnt",   0, 1, 0, 1, 0, 32'h0,        0, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(row("err_rsp",    0, 0, 0, 0, 1, 32'hAAAA,     1, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(row("pre_rst",    0, 0, 1, 1, 0, 32'h0,        0, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(row("mid_rst",    1, 0, 0, 0, 1, 32'h1234,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row("lost_rv",    0, 0, 0, 0, 1, 32'h5678,     0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row("lost_set",   0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i]);
`ifdef USER_ARB_PERF_EN
      if (vecs[i].rst) begin
        total++;
        if ({instr_gnt_cnt_o, data_gnt_cnt_o, stall_cnt_o} !== 96'h0) begin
          bad++;
          $display("FAIL perf_rst: got %h %h %h want 0", instr_gnt_cnt_o, data_gnt_cnt_o,
                   stall_cnt_o);
        end
      end
`endif
    end

    for (int k = 0; k < 5; k++) run(row("sticky", 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1));
    run(row("sticky_rst", 1, 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    run(row("sticky_clr", 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
